// File: rtl/cal_pkg.sv
// Shared definitions for the UART calculator: command encodings, ALU state
// encoding and BCD helpers used by both the decoder and the ALU.
package cal_pkg;

    localparam logic [4:0] OP_ADD = 5'h01;
    localparam logic [4:0] OP_SUB = 5'h02;
    localparam logic [4:0] OP_MUL = 5'h04;
    localparam logic [4:0] OP_DIV = 5'h08;

    localparam logic [3:0] DT_UNS = 4'h1;
    localparam logic [3:0] DT_SGN = 4'h2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONV,
        ST_EXEC,
        ST_DONE
    } alu_state_e;

    // Helpers take up to MAX_DIGITS digits; narrower operands are zero-extended.
    localparam int MAX_DIGITS = 8;

    function automatic logic [31:0] bcd2bin(input logic [4*MAX_DIGITS-1:0] bcd);
        logic [31:0] acc;
        acc = '0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            acc = acc * 32'd10 + {28'd0, bcd[4*i +: 4]};
        end
        return acc;
    endfunction

    function automatic logic bcd_ok(input logic [4*MAX_DIGITS-1:0] bcd);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (bcd[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/cal_divider.sv
// Iterative restoring divider: one quotient bit per cycle, done pulses exactly
// BW cycles after an accepted go. The first bit is resolved in the go cycle.
module cal_divider #(
    parameter int BW = 14
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          go,
    input  logic [BW-1:0] dividend,
    input  logic [BW-1:0] divisor,
    output logic          done,
    output logic [BW-1:0] quot,
    output logic [BW-1:0] rem
);

    localparam int CW = $clog2(BW + 1);

    logic          run_q;
    logic          done_q;
    logic [CW-1:0] cnt_q;
    logic [BW-1:0] quot_q;
    logic [BW-1:0] rem_q;
    logic [BW-1:0] dsr_q;

    logic [BW-1:0] step_r_in;
    logic [BW-1:0] step_q_in;
    logic [BW-1:0] step_d;
    logic [BW:0]   trial;
    logic [BW-1:0] step_r;
    logic [BW-1:0] step_q;
    logic          q_bit;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        step_r_in = run_q ? rem_q  : '0;
        step_q_in = run_q ? quot_q : dividend;
        step_d    = run_q ? dsr_q  : divisor;
        trial     = {step_r_in, step_q_in[BW-1]};
        q_bit     = 1'b0;
        step_r    = trial[BW-1:0];
        if (trial >= {1'b0, step_d}) begin
            q_bit  = 1'b1;
            step_r = BW'(trial - {1'b0, step_d});
        end
        step_q = {step_q_in[BW-2:0], q_bit};
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q  <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dsr_q  <= '0;
        end else begin
            done_q <= 1'b0;
            if (run_q) begin
                rem_q  <= step_r;
                quot_q <= step_q;
                cnt_q  <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end else if (go) begin
                rem_q  <= step_r;
                quot_q <= step_q;
                dsr_q  <= divisor;
                cnt_q  <= CW'(BW - 1);
                run_q  <= 1'b1;
            end
        end
    end

    assign done = done_q;
    assign quot = quot_q;
    assign rem  = rem_q;

endmodule

// File: rtl/cal_alu.sv
// Calculator execution stage: captures a decoded BCD command, converts it to
// binary, runs add/sub/mul or an iterative divide, and returns a registered result.
module cal_alu
    import cal_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BW     = 14,
    parameter int RESW   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [3:0]          dtype,
    input  logic [4:0]          op,
    input  logic [4*DIGITS-1:0] src1,
    input  logic [4*DIGITS-1:0] src2,
    output logic                busy,
    output logic                valid,
    output logic [RESW-1:0]     result,
    output logic [BW-1:0]       rem,
    output logic                err
);

    alu_state_e state_q, state_d;

    logic [3:0]          dtype_q;
    logic [4:0]          op_q;
    logic [4*DIGITS-1:0] src1_q, src2_q;
    logic [BW-1:0]       bin_a_q, bin_b_q;

    logic                busy_q, valid_q, err_q;
    logic [RESW-1:0]     result_q;
    logic [BW-1:0]       rem_q;

    logic [BW-1:0]       conv_a, conv_b;
    logic                conv_err;

    logic                capture, conv_load, out_load, div_go, err_d;
    logic [RESW-1:0]     result_d;
    logic [BW-1:0]       rem_d;

    logic                div_done;
    logic [BW-1:0]       div_quot, div_rem;

    assign conv_a   = BW'(bcd2bin(32'(src1_q)));
    assign conv_b   = BW'(bcd2bin(32'(src2_q)));
    assign conv_err = !bcd_ok(32'(src1_q)) || !bcd_ok(32'(src2_q))
                   || !(dtype_q inside {DT_UNS, DT_SGN})
                   || !(op_q inside {OP_ADD, OP_SUB, OP_MUL, OP_DIV});

    cal_divider #(.BW(BW)) u_div (
        .clk      (clk),
        .rst      (rst),
        .go       (div_go),
        .dividend (conv_a),
        .divisor  (conv_b),
        .done     (div_done),
        .quot     (div_quot),
        .rem      (div_rem)
    );

    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        conv_load = 1'b0;
        div_go    = 1'b0;
        out_load  = 1'b0;
        err_d     = 1'b0;
        result_d  = '0;
        rem_d     = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    capture = 1'b1;
                    state_d = ST_CONV;
                end
            end
            ST_CONV: begin
                conv_load = 1'b1;
                if (conv_err) begin
                    out_load = 1'b1;
                    err_d    = 1'b1;
                end else begin
                    // Divider starts here so its BW-cycle run ends with EXEC.
                    div_go = (op_q == OP_DIV) && (conv_b != '0);
                end
                state_d = conv_err ? ST_DONE : ST_EXEC;
            end
            ST_EXEC: begin
                unique case (op_q)
                    OP_ADD: begin
                        out_load = 1'b1;
                        result_d = RESW'(bin_a_q) + RESW'(bin_b_q);
                    end
                    OP_SUB: begin
                        out_load = 1'b1;
                        if (dtype_q == DT_UNS && bin_a_q < bin_b_q) err_d = 1'b1;
                        else result_d = RESW'(bin_a_q) - RESW'(bin_b_q);
                    end
                    OP_MUL: begin
                        out_load = 1'b1;
                        result_d = RESW'(bin_a_q) * RESW'(bin_b_q);
                    end
                    default: begin
                        if (bin_b_q == '0) begin
                            out_load = 1'b1;
                            err_d    = 1'b1;
                        end else if (div_done) begin
                            out_load = 1'b1;
                            result_d = RESW'(div_quot);
                            rem_d    = div_rem;
                        end
                    end
                endcase
                if (out_load) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
            rem_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == ST_CONV) || (state_d == ST_EXEC);
            valid_q <= (state_d == ST_DONE);
            if (out_load) begin
                result_q <= result_d;
                rem_q    <= rem_d;
                err_q    <= err_d;
            end
        end
    end

    // NOTE: operand registers carry no reset; each is written by the FSM
    // before any state that reads it, so a reset would only add fanout.
    always_ff @(posedge clk) begin
        if (capture) begin
            dtype_q <= dtype;
            op_q    <= op;
            src1_q  <= src1;
            src2_q  <= src2;
        end
        if (conv_load) begin
            bin_a_q <= conv_a;
            bin_b_q <= conv_b;
        end
    end

    assign busy   = busy_q;
    assign valid  = valid_q;
    assign result = result_q;
    assign rem    = rem_q;
    assign err    = err_q;

endmodule

// File: tb/tb_cal_alu.sv
// Directed bench for cal_alu: commands push expected results and valid cycle
// into a scoreboard; a negedge monitor pops and compares on every valid.
module tb_cal_alu;
    import cal_pkg::*;

    localparam int DIGITS = 4;
    localparam int BW     = 14;
    localparam int RESW   = 32;
    localparam int DIV_LAT = 3 + BW - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic [3:0]          dtype;
    logic [4:0]          op;
    logic [4*DIGITS-1:0] src1, src2;
    logic                busy, valid, err;
    logic [RESW-1:0]     result;
    logic [BW-1:0]       rem;

    typedef struct {
        logic [RESW-1:0] res;
        logic [BW-1:0]   rem;
        logic            err;
        int              start_cyc;
        int              exp_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    cal_alu #(.DIGITS(DIGITS), .BW(BW), .RESW(RESW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .dtype  (dtype),
        .op     (op),
        .src1   (src1),
        .src2   (src2),
        .busy   (busy),
        .valid  (valid),
        .result (result),
        .rem    (rem),
        .err    (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic exp_busy;
        if (!rst) begin
            exp_busy = 1'b0;
            if (sb.size() > 0)
                exp_busy = (cyc > sb[0].start_cyc) && (cyc < sb[0].exp_cyc);
            check("busy", {31'd0, busy}, {31'd0, exp_busy});
            if (valid) begin
                if (sb.size() == 0) begin
                    check("spurious_valid", {31'd0, valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("latency", cyc, e.exp_cyc);
                    check("result", result, e.res);
                    check("rem", {18'd0, rem}, {18'd0, e.rem});
                    check("err", {31'd0, err}, {31'd0, e.err});
                end
            end else if (sb.size() > 0 && cyc >= sb[0].exp_cyc) begin
                check("valid_missing", {31'd0, valid}, 32'd1);
            end
        end
    end

    task automatic issue(input logic [3:0] dt, input logic [4:0] o,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] e_res, input logic [13:0] e_rem,
                         input logic e_err, input int lat);
        @(negedge clk);
        dtype = dt;
        op    = o;
        src1  = a;
        src2  = b;
        start = 1'b1;
        sb.push_back('{e_res, e_rem, e_err, cyc, cyc + lat});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() > 0; i++) @(negedge clk);
        check("drain_timeout", sb.size(), 0);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        dtype = '0;
        op    = '0;
        src1  = '0;
        src2  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",   {31'd0, busy},  32'd0);
        check("rst_valid",  {31'd0, valid}, 32'd0);
        check("rst_result", result,         32'd0);
        check("rst_rem",    {18'd0, rem},   32'd0);
        check("rst_err",    {31'd0, err},   32'd0);
        rst = 1'b0;

        issue(DT_UNS, OP_ADD, 16'h1234, 16'h0567, 32'h0000_0709, 14'd0, 1'b0, 3);
        drain();
        issue(DT_UNS, OP_SUB, 16'h0012, 16'h0034, 32'd0, 14'd0, 1'b1, 3);
        drain();
        issue(DT_SGN, OP_SUB, 16'h0012, 16'h0034, 32'hFFFF_FFEA, 14'd0, 1'b0, 3);
        drain();
        issue(DT_UNS, OP_SUB, 16'h0034, 16'h0012, 32'd22, 14'd0, 1'b0, 3);
        drain();
        issue(DT_UNS, OP_MUL, 16'h9999, 16'h9999, 32'h05F5_92E1, 14'd0, 1'b0, 3);
        drain();
        issue(DT_UNS, OP_DIV, 16'h0100, 16'h0007, 32'd14, 14'd2, 1'b0, DIV_LAT);
        drain();
        issue(DT_SGN, OP_DIV, 16'h0100, 16'h0007, 32'd14, 14'd2, 1'b0, DIV_LAT);
        drain();
        issue(DT_UNS, OP_DIV, 16'h0100, 16'h0000, 32'd0, 14'd0, 1'b1, 3);
        drain();
        issue(DT_UNS, OP_ADD, 16'h12A4, 16'h0001, 32'd0, 14'd0, 1'b1, 2);
        drain();
        issue(DT_UNS, OP_MUL, 16'h0003, 16'h00F0, 32'd0, 14'd0, 1'b1, 2);
        drain();
        issue(DT_UNS, 5'h10, 16'h0001, 16'h0001, 32'd0, 14'd0, 1'b1, 2);
        drain();
        issue(4'h3, OP_ADD, 16'h0001, 16'h0001, 32'd0, 14'd0, 1'b1, 2);
        drain();

        // A second start mid-divide must be ignored entirely.
        issue(DT_UNS, OP_DIV, 16'h9999, 16'h0003, 32'd3333, 14'd0, 1'b0, DIV_LAT);
        repeat (4) @(negedge clk);
        dtype = DT_UNS;
        op    = OP_ADD;
        src1  = 16'h0005;
        src2  = 16'h0005;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (5) @(negedge clk);

        // Reset in the middle of a divide aborts it without a valid.
        issue(DT_UNS, OP_DIV, 16'h0999, 16'h0010, 32'd99, 14'd9, 1'b0, DIV_LAT);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check("mid_rst_busy",   {31'd0, busy},  32'd0);
        check("mid_rst_valid",  {31'd0, valid}, 32'd0);
        check("mid_rst_result", result,         32'd0);
        check("mid_rst_rem",    {18'd0, rem},   32'd0);
        check("mid_rst_err",    {31'd0, err},   32'd0);
        rst = 1'b0;
        repeat (20) @(negedge clk);

        issue(DT_UNS, OP_ADD, 16'h0001, 16'h0002, 32'd3, 14'd0, 1'b0, 3);
        drain();
        issue(DT_UNS, OP_DIV, 16'h0999, 16'h0010, 32'd99, 14'd9, 1'b0, DIV_LAT);
        drain();

        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
